// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 data-memory AHB-Lite master.
package msrv32_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_ADDR = 2'd1,
    DMEM_DATA = 2'd2,
    DMEM_ERR  = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/msrv32_dmem_size_decode.sv
// Combinational decode of a write mask or read size/address into HSIZE,
// byte offset within the word and a legality flag.
module msrv32_dmem_size_decode
  import msrv32_pkg::*;
(
  input  logic       wr_sel_i,
  input  logic [3:0] wr_mask_i,
  input  logic [1:0] rd_size_i,
  input  logic [1:0] rd_addr_lo_i,
  output logic [2:0] hsize_o,
  output logic [1:0] offset_o,
  output logic       legal_o
);

  always_comb begin
    hsize_o  = HSIZE_BYTE;
    offset_o = 2'b00;
    legal_o  = 1'b0;
    if (wr_sel_i) begin
      legal_o = 1'b1;
      case (wr_mask_i)
        4'b1111: hsize_o = HSIZE_WORD;
        4'b0011: hsize_o = HSIZE_HALF;
        4'b1100: begin
          hsize_o  = HSIZE_HALF;
          offset_o = 2'b10;
        end
        4'b0001: offset_o = 2'b00;
        4'b0010: offset_o = 2'b01;
        4'b0100: offset_o = 2'b10;
        4'b1000: offset_o = 2'b11;
        default: legal_o = 1'b0;
      endcase
    end else begin
      offset_o = rd_addr_lo_i;
      case (rd_size_i)
        2'b00: begin
          hsize_o = HSIZE_BYTE;
          legal_o = 1'b1;
        end
        2'b01: begin
          hsize_o = HSIZE_HALF;
          legal_o = ~rd_addr_lo_i[0];
        end
        2'b10: begin
          hsize_o = HSIZE_WORD;
          legal_o = (rd_addr_lo_i == 2'b00);
        end
        default: legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/msrv32_dmem_ahb_master.sv
// Single-transfer AHB-Lite master for the data-memory port (stores and loads),
// one outstanding transfer, fully registered outputs.
module msrv32_dmem_ahb_master
  import msrv32_pkg::*;
(
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic [31:0] dmaddr_in,
  input  logic [31:0] dmdata_in,
  input  logic [3:0]  dmwr_mask_in,
  input  logic        dmwr_req_in,
  input  logic        dmrd_req_in,
  input  logic [31:0] dmrd_addr_in,
  input  logic [1:0]  dmrd_size_in,
  input  logic        ahb_hready_in,
  input  logic        ahb_hresp_in,
  input  logic [31:0] ahb_hrdata_in,
  output logic [31:0] ahb_haddr_out,
  output logic [1:0]  ahb_htrans_out,
  output logic        ahb_hwrite_out,
  output logic [2:0]  ahb_hsize_out,
  output logic [31:0] ahb_hwdata_out,
  output logic        ahb_ready_out,
  output logic [31:0] rdata_out,
  output logic        rdata_valid_out,
  output logic        err_out
);

  dmem_state_t state_q, state_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        hwrite_q, hwrite_d, ready_q, ready_d;
  logic        rvalid_q, rvalid_d, err_q, err_d;

  logic        wr_sel;
  logic [2:0]  dec_hsize;
  logic [1:0]  dec_offset;
  logic        dec_legal;
  logic [29:0] req_word;

  // A write always takes the slot; a simultaneous read is left pending.
  assign wr_sel   = dmwr_req_in;
  assign req_word = wr_sel ? dmaddr_in[31:2] : dmrd_addr_in[31:2];

  msrv32_dmem_size_decode u_size_decode (
    .wr_sel_i     (wr_sel),
    .wr_mask_i    (dmwr_mask_in),
    .rd_size_i    (dmrd_size_in),
    .rd_addr_lo_i (dmrd_addr_in[1:0]),
    .hsize_o      (dec_hsize),
    .offset_o     (dec_offset),
    .legal_o      (dec_legal)
  );

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    htrans_d = htrans_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    ready_d  = ready_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (dmwr_req_in || dmrd_req_in) begin
          if (dec_legal) begin
            haddr_d  = {req_word, dec_offset};
            hsize_d  = dec_hsize;
            hwrite_d = wr_sel;
            if (wr_sel) wdata_d = dmdata_in;
            htrans_d = HTRANS_NONSEQ;
            ready_d  = 1'b0;
            state_d  = DMEM_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DMEM_ADDR: begin
        if (ahb_hready_in) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
          state_d  = DMEM_DATA;
        end
      end
      DMEM_DATA: begin
        // First cycle of the two-cycle ERROR response moves us to ERR.
        if (ahb_hresp_in) begin
          state_d = DMEM_ERR;
        end else if (ahb_hready_in) begin
          if (!hwrite_q) begin
            rdata_d  = ahb_hrdata_in;
            rvalid_d = 1'b1;
          end
          ready_d = 1'b1;
          state_d = DMEM_IDLE;
        end
      end
      DMEM_ERR: begin
        if (ahb_hready_in) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = DMEM_IDLE;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q  <= DMEM_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hsize_q  <= HSIZE_BYTE;
      hwrite_q <= 1'b0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      htrans_q <= htrans_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign ahb_haddr_out   = haddr_q;
  assign ahb_htrans_out  = htrans_q;
  assign ahb_hwrite_out  = hwrite_q;
  assign ahb_hsize_out   = hsize_q;
  assign ahb_hwdata_out  = hwdata_q;
  assign ahb_ready_out   = ready_q;
  assign rdata_out       = rdata_q;
  assign rdata_valid_out = rvalid_q;
  assign err_out         = err_q;

endmodule
